// File: rtl/pixel_out_pkg.sv
// Shared widths, colour field positions and colour expansion helpers for pixel_out_stage.
package pixel_out_pkg;

    localparam int CORDW   = 10;
    localparam int COLOR_W = 10;

    localparam int R_HI = 9;
    localparam int R_LO = 7;
    localparam int G_HI = 6;
    localparam int G_LO = 3;
    localparam int B_HI = 2;
    localparam int B_LO = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Bit replication keeps 0 -> 00 and full scale -> FF.
    function automatic logic [7:0] expand3(input logic [2:0] v);
        return {v, v, v[2:1]};
    endfunction

    function automatic logic [7:0] expand4(input logic [3:0] v);
        return {v, v};
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register whose stages all clear on asynchronous reset.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/pixel_out_stage.sv
// Aligns timing-generator coordinates with raymarcher colour, expands RGB343 to RGB888 and tracks frames.
// Optional centre crosshair overlay is built only when OVERLAY_EN is defined.
module pixel_out_stage #(
    parameter int CORDW   = pixel_out_pkg::CORDW,
    parameter int COLOR_W = pixel_out_pkg::COLOR_W,
    parameter int RD_LAT  = 2,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480
) (
    input  logic               clk_pix,
    input  logic               rst_pix_n,
    input  logic [CORDW-1:0]   in_sx,
    input  logic [CORDW-1:0]   in_sy,
    input  logic               in_de,
    input  logic [COLOR_W-1:0] rd_color,
    output logic [CORDW-1:0]   out_sx,
    output logic [CORDW-1:0]   out_sy,
    output logic               out_de,
    output logic [7:0]         out_r,
    output logic [7:0]         out_g,
    output logic [7:0]         out_b,
    output logic               frame_start,
    output logic [15:0]        frame_count,
    output logic               frame_err
);

    import pixel_out_pkg::*;

    localparam int          TAP_W     = 2*CORDW + 1;
    localparam logic [19:0] FRAME_PIX = 20'(H_RES * V_RES);

    logic [TAP_W-1:0] tap;
    logic [CORDW-1:0] tap_sx;
    logic [CORDW-1:0] tap_sy;
    logic             tap_de;

    pipe_delay #(.WIDTH(TAP_W), .DEPTH(RD_LAT)) u_tap_delay (
        .clk  (clk_pix),
        .rst_n(rst_pix_n),
        .din  ({in_sx, in_sy, in_de}),
        .dout (tap)
    );

    assign {tap_sx, tap_sy, tap_de} = tap;

    logic overlay_hit;

`ifdef OVERLAY_EN
    localparam logic signed [CORDW+1:0] XH_ARM = (CORDW+2)'(8);

    logic signed [CORDW+1:0] dx;
    logic signed [CORDW+1:0] dy;

    always_comb begin
        dx = $signed({2'b00, tap_sx}) - $signed((CORDW+2)'(H_RES/2));
        dy = $signed({2'b00, tap_sy}) - $signed((CORDW+2)'(V_RES/2));
        overlay_hit = ((dx == '0) && (dy >= -XH_ARM) && (dy <= XH_ARM)) ||
                      ((dy == '0) && (dx >= -XH_ARM) && (dx <= XH_ARM));
    end
`else
    assign overlay_hit = 1'b0;
`endif

    rgb888_t rgb_d, rgb_q;

    always_comb begin
        rgb_d = '0;
        if (tap_de) begin
            rgb_d.r = expand3(rd_color[R_HI:R_LO]);
            rgb_d.g = expand4(rd_color[G_HI:G_LO]);
            rgb_d.b = expand3(rd_color[B_HI:B_LO]);
            if (overlay_hit) begin
                rgb_d = '1;
            end
        end
    end

    logic        frame_start_d, frame_start_q;
    logic [15:0] frame_count_d, frame_count_q;
    logic [19:0] pix_cnt_d, pix_cnt_q;
    logic        frame_seen_d, frame_seen_q;
    logic        frame_err_d, frame_err_q;

    // The first frame_start after reset only arms the check, so a mid-frame reset cannot flag an error.
    always_comb begin
        frame_start_d = tap_de && (tap_sx == '0) && (tap_sy == '0);
        frame_count_d = frame_count_q;
        pix_cnt_d     = pix_cnt_q;
        frame_seen_d  = frame_seen_q;
        frame_err_d   = frame_err_q;
        if (frame_start_d) begin
            frame_count_d = frame_count_q + 16'd1;
            pix_cnt_d     = 20'd1;
            frame_seen_d  = 1'b1;
            if (frame_seen_q && (pix_cnt_q != FRAME_PIX)) begin
                frame_err_d = 1'b1;
            end
        end else if (tap_de && (pix_cnt_q != '1)) begin
            pix_cnt_d = pix_cnt_q + 20'd1;
        end
    end

    logic [CORDW-1:0] out_sx_q, out_sy_q;
    logic             out_de_q;

    // Output register stage: RD_LAT + 1 cycles from in_* to out_*.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            out_sx_q      <= '0;
            out_sy_q      <= '0;
            out_de_q      <= 1'b0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
            pix_cnt_q     <= '0;
            frame_seen_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            out_sx_q      <= tap_sx;
            out_sy_q      <= tap_sy;
            out_de_q      <= tap_de;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            pix_cnt_q     <= pix_cnt_d;
            frame_seen_q  <= frame_seen_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign out_sx      = out_sx_q;
    assign out_sy      = out_sy_q;
    assign out_de      = out_de_q;
    assign out_r       = rgb_q.r;
    assign out_g       = rgb_q.g;
    assign out_b       = rgb_q.b;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_pixel_out_stage.sv
// Bench for pixel_out_stage: spec-level model compared every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_pixel_out_stage;

    localparam int CORDW   = 10;
    localparam int COLOR_W = 10;
    localparam int RD_LAT  = 2;
    localparam int H_RES   = 20;
    localparam int V_RES   = 12;
    localparam int H_TOT   = 24;
    localparam int V_TOT   = 14;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [CORDW-1:0]   in_sx = '0;
    logic [CORDW-1:0]   in_sy = '0;
    logic               in_de = 1'b0;
    logic [COLOR_W-1:0] rd_color = '0;
    logic [CORDW-1:0]   out_sx, out_sy;
    logic               out_de;
    logic [7:0]         out_r, out_g, out_b;
    logic               frame_start;
    logic [15:0]        frame_count;
    logic               frame_err;

    always #5 clk = ~clk;

    pixel_out_stage #(
        .CORDW(CORDW), .COLOR_W(COLOR_W), .RD_LAT(RD_LAT), .H_RES(H_RES), .V_RES(V_RES)
    ) dut (
        .clk_pix    (clk),
        .rst_pix_n  (rst_n),
        .in_sx      (in_sx),
        .in_sy      (in_sy),
        .in_de      (in_de),
        .rd_color   (rd_color),
        .out_sx     (out_sx),
        .out_sy     (out_sy),
        .out_de     (out_de),
        .out_r      (out_r),
        .out_g      (out_g),
        .out_b      (out_b),
        .frame_start(frame_start),
        .frame_count(frame_count),
        .frame_err  (frame_err)
    );

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    int fs_pulses = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [CORDW-1:0] sx;
        logic [CORDW-1:0] sy;
        logic             de;
    } pix_t;

    pix_t        dq[$];
    logic [CORDW-1:0] e_sx = '0, e_sy = '0;
    logic        e_de = 1'b0;
    logic [7:0]  e_r = '0, e_g = '0, e_b = '0;
    logic        e_fs = 1'b0;
    logic [15:0] e_fc = '0;
    logic        e_err = 1'b0;
    int          m_cnt = 0;
    bit          m_seen = 1'b0;

    function automatic logic [7:0] x3(input int v);
        return 8'(v * 36 + v / 2);
    endfunction

    function automatic logic [7:0] x4(input int v);
        return 8'(v * 17);
    endfunction

`ifdef OVERLAY_EN
    function automatic bit on_cross(input int sx, input int sy);
        int ax, ay;
        ax = (sx > H_RES/2) ? sx - H_RES/2 : H_RES/2 - sx;
        ay = (sy > V_RES/2) ? sy - V_RES/2 : V_RES/2 - sy;
        return (sx == H_RES/2 && ay <= 8) || (sy == V_RES/2 && ax <= 8);
    endfunction
`endif

    initial begin
        pix_t t;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                dq.delete();
                for (int i = 0; i < RD_LAT; i++) dq.push_back('0);
                e_sx = '0; e_sy = '0; e_de = 0; e_r = 0; e_g = 0; e_b = 0;
                e_fs = 0; e_fc = 0; e_err = 0; m_cnt = 0; m_seen = 0;
            end else begin
                t = dq.pop_front();
                dq.push_back(pix_t'{in_sx, in_sy, in_de});
                e_sx = t.sx; e_sy = t.sy; e_de = t.de;
                e_r = 0; e_g = 0; e_b = 0;
                if (t.de) begin
                    e_r = x3(int'(rd_color[9:7]));
                    e_g = x4(int'(rd_color[6:3]));
                    e_b = x3(int'(rd_color[2:0]));
`ifdef OVERLAY_EN
                    if (on_cross(int'(t.sx), int'(t.sy))) begin
                        e_r = 8'hFF; e_g = 8'hFF; e_b = 8'hFF;
                    end
`endif
                end
                e_fs = t.de && t.sx == 0 && t.sy == 0;
                if (e_fs) begin
                    e_fc = e_fc + 16'd1;
                    if (m_seen && m_cnt != H_RES * V_RES) e_err = 1'b1;
                    m_cnt = 1;
                    m_seen = 1'b1;
                end else if (t.de && m_cnt < 20'hFFFFF) begin
                    m_cnt++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (frame_start === 1'b1) fs_pulses++;
            if (chk_en) begin
                chk("cycle", {1'b0, out_sx, out_sy, out_de, out_r, out_g, out_b, frame_start, frame_count, frame_err},
                             {1'b0, e_sx, e_sy, e_de, e_r, e_g, e_b, e_fs, e_fc, e_err});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pix(input int sx, input int sy, input logic de, input int col);
        @(posedge clk);
        #1;
        in_sx = CORDW'(sx);
        in_sy = CORDW'(sy);
        in_de = de;
        rd_color = COLOR_W'(col);
    endtask

    task automatic settle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_frame(input int drop_x, input int drop_y);
        for (int y = 0; y < V_TOT; y++) begin
            for (int x = 0; x < H_TOT; x++) begin
                pix(x, y, (x < H_RES) && (y < V_RES) && !(x == drop_x && y == drop_y),
                    int'($urandom_range(0, 1023)));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        rst_n = 1'b0;
        chk_en = 1'b1;

        // T1: outputs stay cleared while reset is held with toggling inputs
        for (int i = 0; i < 4; i++) begin
            pix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)));
            @(negedge clk);
            chk("reset_zero", {out_sx, out_sy, out_de, out_r, out_g, out_b, frame_start, frame_count, frame_err}, '0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_sx = 10'd3; in_sy = 10'd2; in_de = 1'b1; rd_color = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("release_de", 64'(out_de), 64'(i == 3));
        end

        // T2: latency
        pix(5, 7, 1'b1, 0);
        pix(6, 7, 1'b1, 0);
        pix(7, 7, 1'b1, 10'b111_0000_000);
        settle();
        chk("lat_sx", 64'(out_sx), 64'd5);
        chk("lat_r", 64'(out_r), 64'hFF);
        chk("lat_g", 64'(out_g), 64'h00);
        chk("lat_b", 64'(out_b), 64'h00);

        // T3: expansion
        pix(9, 9, 1'b1, 0);
        pix(9, 9, 1'b1, 0);
        pix(10, 9, 1'b1, 10'b100_1010_011);
        settle();
        chk("exp_r", 64'(out_r), 64'h92);
        chk("exp_g", 64'(out_g), 64'hAA);
        chk("exp_b", 64'(out_b), 64'h6D);

        // T4: blanking
        pix(4, 4, 1'b0, 0);
        pix(4, 4, 1'b0, 0);
        pix(5, 4, 1'b0, 10'h3FF);
        settle();
        chk("blank_rgb", 64'({out_r, out_g, out_b}), 64'h0);
        chk("blank_de", 64'(out_de), 64'h0);

        // T6: crosshair centre
        pix(H_RES/2, V_RES/2, 1'b1, 0);
        pix(H_RES/2 + 1, V_RES/2, 1'b1, 0);
        pix(H_RES/2 + 2, V_RES/2, 1'b1, 0);
        settle();
        chk("ovl_sx", 64'(out_sx), 64'(H_RES/2));
`ifdef OVERLAY_EN
        chk("ovl_rgb", 64'({out_r, out_g, out_b}), 64'hFFFFFF);
`else
        chk("ovl_rgb", 64'({out_r, out_g, out_b}), 64'h000000);
`endif

        // T5: frames
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        fs_pulses = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(-1, -1);
        run_frame(-1, -1);
        pix(H_TOT - 1, V_TOT - 1, 1'b0, 0);
        pix(H_TOT - 1, V_TOT - 1, 1'b0, 0);
        pix(H_TOT - 1, V_TOT - 1, 1'b0, 0);
        settle();
        chk("two_frames_cnt", 64'(frame_count), 64'd2);
        chk("two_frames_pulses", 64'(fs_pulses), 64'd2);
        chk("two_frames_err", 64'(frame_err), 64'd0);
        run_frame(3, 2);
        pix(0, 0, 1'b1, 0);
        pix(1, 0, 1'b1, 0);
        pix(2, 0, 1'b1, 0);
        settle();
        chk("f4_start", 64'(frame_start), 64'd1);
        chk("f4_err", 64'(frame_err), 64'd1);
        chk("f4_count", 64'(frame_count), 64'd4);
        pix(H_TOT - 1, V_TOT - 1, 1'b0, 0);
        settle();
        chk("err_sticky", 64'(frame_err), 64'd1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
